// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam int unsigned DEFAULT_NUM_REGS = 32;
  localparam int unsigned DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);
  localparam int unsigned ZERO_REG         = 0;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero-register override, write bypass and busy lookup.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   regs_i [NUM_REGS],
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   wr_i,
  input  logic [DATA_W-1:0]   wd_i,
  input  logic [NUM_REGS-1:0] busy_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                busy_o
);

  logic hit;

  always_comb begin
    hit    = (BYPASS != 0) && we_i && (wr_i == addr_i);
    data_o = regs_i[addr_i];
    busy_o = busy_i[addr_i];
    if (addr_i == ADDR_W'(ZERO_REG)) begin
      data_o = '0;
      busy_o = 1'b0;
    end else if (hit) begin
      // The forwarded write retires the pending producer in this same cycle.
      data_o = wd_i;
      busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with N read ports, write bypass and a per-register busy scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS),
  localparam int unsigned CNT_W   = ADDR_W + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rr,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wr,
  input  logic [DATA_W-1:0]          wd,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_rd,
  input  logic                       flush,
  output logic [CNT_W-1:0]           busy_cnt
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    busy_cnt_q, busy_cnt_d;
  logic                wr_en;

  assign wr_en = we && (wr != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr] <= wd;
    end
  end

  // Flush beats issue beats writeback; issue after write lets a new producer win.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (we) busy_d[wr] = 1'b0;
      if (iss_valid) busy_d[iss_rd] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;

    busy_cnt_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [DATA_W-1:0] port_data;
    logic              port_busy;

    regfile_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .BYPASS   (BYPASS)
    ) u_read_port (
      .addr_i (rr[i*ADDR_W +: ADDR_W]),
      .regs_i (regs_q),
      .we_i   (we),
      .wr_i   (wr),
      .wd_i   (wd),
      .busy_i (busy_q),
      .data_o (port_data),
      .busy_o (port_busy)
    );

    assign rd[i*DATA_W +: DATA_W] = rst_n ? port_data : '0;
    assign rd_busy[i]             = rst_n & port_busy;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: default instance (bypass) plus a 64-bit/16-reg/3-port no-bypass instance.
module tb_regfile_scoreboard;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  // Instance A: defaults (32x32, 2 read ports, bypass on)
  logic [9:0]  rr_a        = '0;
  logic [63:0] rd_a;
  logic [1:0]  rd_busy_a;
  logic        we_a        = 1'b0;
  logic [4:0]  wr_a        = '0;
  logic [31:0] wd_a        = '0;
  logic        iss_valid_a = 1'b0;
  logic [4:0]  iss_rd_a    = '0;
  logic        flush_a     = 1'b0;
  logic [5:0]  busy_cnt_a;

  // Instance B: 64-bit, 16 regs, 3 read ports, bypass off
  logic [11:0]  rr_b        = '0;
  logic [191:0] rd_b;
  logic [2:0]   rd_busy_b;
  logic         we_b        = 1'b0;
  logic [3:0]   wr_b        = '0;
  logic [63:0]  wd_b        = '0;
  logic         iss_valid_b = 1'b0;
  logic [3:0]   iss_rd_b    = '0;
  logic         flush_b     = 1'b0;
  logic [4:0]   busy_cnt_b;

  logic [63:0] expq [$];
  logic [63:0] exp_v, got;
  int checks   = 0;
  int failures = 0;

  regfile_scoreboard u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .rr        (rr_a),
    .rd        (rd_a),
    .rd_busy   (rd_busy_a),
    .we        (we_a),
    .wr        (wr_a),
    .wd        (wd_a),
    .iss_valid (iss_valid_a),
    .iss_rd    (iss_rd_a),
    .flush     (flush_a),
    .busy_cnt  (busy_cnt_a)
  );

  regfile_scoreboard #(
    .DATA_W   (64),
    .NUM_REGS (16),
    .NUM_RD   (3),
    .BYPASS   (0)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .rr        (rr_b),
    .rd        (rd_b),
    .rd_busy   (rd_busy_b),
    .we        (we_b),
    .wr        (wr_b),
    .wd        (wd_b),
    .iss_valid (iss_valid_b),
    .iss_rd    (iss_rd_b),
    .flush     (flush_b),
    .busy_cnt  (busy_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] val_b(int i);
    return 64'hc0de_0000_5a5a_0000 + 64'(i) * 64'h0000_0001_0000_0001;
  endfunction

  task automatic test_reset();
    we_a = 1'b1; wr_a = 5'd5; wd_a = 32'ha5a5a5a5;
    iss_valid_a = 1'b1; iss_rd_a = 5'd5;
    tick();
    we_a = 1'b0; iss_valid_a = 1'b0; rr_a[4:0] = 5'd5;
    expq.push_back(64'ha5a5a5a5);
    expq.push_back(64'd1);
    expq.push_back(64'd1);
    #2;
    got = 64'(rd_a[31:0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t1_preload got=%h exp=%h", got, exp_v); end
    got = 64'(rd_busy_a[0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t1_pre_busy got=%h exp=%h", got, exp_v); end
    got = 64'(busy_cnt_a); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t1_pre_cnt got=%h exp=%h", got, exp_v); end

    rst_n = 1'b0;
    expq.push_back(64'd0);
    expq.push_back(64'd0);
    #2;
    got = 64'(rd_a[31:0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t1_rd_in_rst got=%h exp=%h", got, exp_v); end
    got = 64'(rd_busy_a[0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t1_busy_in_rst got=%h exp=%h", got, exp_v); end

    tick();
    rst_n = 1'b1;
    expq.push_back(64'd0);
    expq.push_back(64'd0);
    expq.push_back(64'd0);
    #2;
    got = 64'(rd_a[31:0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t1_rd_x5 got=%h exp=%h", got, exp_v); end
    got = 64'(rd_busy_a[0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t1_rd_busy got=%h exp=%h", got, exp_v); end
    got = 64'(busy_cnt_a); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t1_busy_cnt got=%h exp=%h", got, exp_v); end
    tick();
  endtask

  task automatic test_write_read();
    we_a = 1'b1; wr_a = 5'd10; wd_a = 32'hdeadbeef;
    rr_a[4:0] = 5'd10; rr_a[9:5] = 5'd11;
    expq.push_back(64'hdeadbeef);
    #2;
    got = 64'(rd_a[31:0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t2_bypass got=%h exp=%h", got, exp_v); end
    tick();
    we_a = 1'b0;
    expq.push_back(64'hdeadbeef);
    expq.push_back(64'd0);
    #2;
    got = 64'(rd_a[31:0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t2_stored got=%h exp=%h", got, exp_v); end
    got = 64'(rd_a[63:32]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t2_port1_x11 got=%h exp=%h", got, exp_v); end
    tick();
  endtask

  task automatic test_zero_reg();
    we_a = 1'b1; wr_a = 5'd0; wd_a = 32'h12345678; rr_a[4:0] = 5'd0;
    iss_valid_a = 1'b1; iss_rd_a = 5'd0;
    expq.push_back(64'd0);
    #2;
    got = 64'(rd_a[31:0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t3_same_cycle got=%h exp=%h", got, exp_v); end
    tick();
    we_a = 1'b0; iss_valid_a = 1'b0;
    expq.push_back(64'd0);
    expq.push_back(64'd0);
    expq.push_back(64'd0);
    #2;
    got = 64'(rd_a[31:0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t3_next_cycle got=%h exp=%h", got, exp_v); end
    got = 64'(busy_cnt_a); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t3_busy_cnt got=%h exp=%h", got, exp_v); end
    got = 64'(rd_busy_a[0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t3_rd_busy got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_scoreboard();
    iss_valid_a = 1'b1; iss_rd_a = 5'd20; rr_a[4:0] = 5'd20;
    tick();
    iss_valid_a = 1'b0;
    expq.push_back(64'd1);
    expq.push_back(64'd1);
    #2;
    got = 64'(rd_busy_a[0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t4_issue_busy got=%h exp=%h", got, exp_v); end
    got = 64'(busy_cnt_a); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t4_issue_cnt got=%h exp=%h", got, exp_v); end

    we_a = 1'b1; wr_a = 5'd20; wd_a = 32'hfacecafe;
    expq.push_back(64'd0);
    expq.push_back(64'hfacecafe);
    expq.push_back(64'd1);
    #2;
    got = 64'(rd_busy_a[0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t4_wb_busy got=%h exp=%h", got, exp_v); end
    got = 64'(rd_a[31:0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t4_wb_data got=%h exp=%h", got, exp_v); end
    got = 64'(busy_cnt_a); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t4_wb_cnt_pre got=%h exp=%h", got, exp_v); end
    tick();
    we_a = 1'b0;
    expq.push_back(64'd0);
    #2;
    got = 64'(busy_cnt_a); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t4_wb_cnt_post got=%h exp=%h", got, exp_v); end

    // Re-issue of a busy register must not double-count.
    iss_valid_a = 1'b1; iss_rd_a = 5'd21;
    tick();
    tick();
    iss_valid_a = 1'b0;
    expq.push_back(64'd1);
    #2;
    got = 64'(busy_cnt_a); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t4_reissue_cnt got=%h exp=%h", got, exp_v); end
    we_a = 1'b1; wr_a = 5'd22; wd_a = 32'd1;
    tick();
    we_a = 1'b0;
    expq.push_back(64'd1);
    #2;
    got = 64'(busy_cnt_a); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t4_idle_wr_cnt got=%h exp=%h", got, exp_v); end
    we_a = 1'b1; wr_a = 5'd21; wd_a = 32'd2;
    tick();
    we_a = 1'b0;
    expq.push_back(64'd0);
    #2;
    got = 64'(busy_cnt_a); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t4_x21_wb_cnt got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_simultaneous();
    iss_valid_a = 1'b1; iss_rd_a = 5'd7;
    we_a = 1'b1; wr_a = 5'd7; wd_a = 32'd1;
    tick();
    iss_valid_a = 1'b0; we_a = 1'b0; rr_a[4:0] = 5'd7;
    expq.push_back(64'd1);
    expq.push_back(64'd1);
    expq.push_back(64'd1);
    #2;
    got = 64'(rd_a[31:0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t5_x7_data got=%h exp=%h", got, exp_v); end
    got = 64'(rd_busy_a[0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t5_x7_busy got=%h exp=%h", got, exp_v); end
    got = 64'(busy_cnt_a); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t5_x7_cnt got=%h exp=%h", got, exp_v); end

    flush_a = 1'b1; iss_valid_a = 1'b1; iss_rd_a = 5'd8;
    tick();
    flush_a = 1'b0; iss_valid_a = 1'b0; rr_a[9:5] = 5'd8;
    expq.push_back(64'd0);
    expq.push_back(64'd0);
    expq.push_back(64'd0);
    #2;
    got = 64'(busy_cnt_a); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t5_flush_cnt got=%h exp=%h", got, exp_v); end
    got = 64'(rd_busy_a[1]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t5_x8_busy got=%h exp=%h", got, exp_v); end
    got = 64'(rd_busy_a[0]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t5_x7_flushed got=%h exp=%h", got, exp_v); end
    tick();
  endtask

  task automatic test_param_sweep();
    for (int i = 1; i < 16; i++) begin
      we_b = 1'b1; wr_b = 4'(i); wd_b = val_b(i);
      tick();
    end
    we_b = 1'b0;

    rr_b = {4'd15, 4'd9, 4'd3};
    expq.push_back(val_b(3));
    expq.push_back(val_b(9));
    expq.push_back(val_b(15));
    #2;
    for (int p = 0; p < 3; p++) begin
      got = rd_b[p*64 +: 64]; exp_v = expq.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++; $display("FAIL t6_read_a port%0d got=%h exp=%h", p, got, exp_v);
      end
    end
    tick();

    rr_b = {4'd1, 4'd14, 4'd0};
    expq.push_back(64'd0);
    expq.push_back(val_b(14));
    expq.push_back(val_b(1));
    #2;
    for (int p = 0; p < 3; p++) begin
      got = rd_b[p*64 +: 64]; exp_v = expq.pop_front(); checks++;
      if (got !== exp_v) begin
        failures++; $display("FAIL t6_read_b port%0d got=%h exp=%h", p, got, exp_v);
      end
    end
    tick();

    iss_valid_b = 1'b1; iss_rd_b = 4'd9;
    tick();
    iss_valid_b = 1'b0;
    we_b = 1'b1; wr_b = 4'd9; wd_b = 64'hffff_0000_ffff_0000;
    rr_b = {4'd2, 4'd9, 4'd0};
    expq.push_back(val_b(9));
    expq.push_back(64'd1);
    #2;
    got = rd_b[127:64]; exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t6_no_bypass got=%h exp=%h", got, exp_v); end
    got = 64'(rd_busy_b[1]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t6_wb_busy got=%h exp=%h", got, exp_v); end
    tick();
    we_b = 1'b0;
    expq.push_back(64'hffff_0000_ffff_0000);
    expq.push_back(64'd0);
    expq.push_back(64'd0);
    #2;
    got = rd_b[127:64]; exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t6_after_edge got=%h exp=%h", got, exp_v); end
    got = 64'(rd_busy_b[1]); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t6_busy_post got=%h exp=%h", got, exp_v); end
    got = 64'(busy_cnt_b); exp_v = expq.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL t6_cnt_post got=%h exp=%h", got, exp_v); end
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_simultaneous();
    test_param_sweep();
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
